memory_access: RTL
==================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have port clk_i, input, 1: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset_i, input, 1: reset, asynchronous and active-high.
REQ-003 SHALL have upstream inputs: valid_i 1; alu_result_i 32 (result/address); store_data_i 32; mem_read_i 1; mem_write_i 1; funct3_i 3; pcsrc_i 32; offset_i 32; mem_to_reg_i 2; rd_i 5; reg_write_i 1.
REQ-004 SHALL have stall_o, output, 1: when high, the upstream stage holds its inputs; when low, the inputs are consumed at this edge.
REQ-005 SHALL have data-memory ports: dmem_req_o 1; dmem_we_o 1; dmem_addr_o 32 (word-aligned, bits[1:0]=0); dmem_wdata_o 32; dmem_be_o 4; dmem_ack_i 1 (input); dmem_rdata_i 32 (input).
REQ-006 SHALL have writeback outputs (all registered): valid_o 1; data_read_o 32; alu_result_o 32; pcsrc_o 32; offset_o 32; mem_to_reg_o 2; rd_o 5; reg_write_o 1; misaligned_o 1.

Function
REQ-007 SHALL implement a two-state FSM, IDLE and BUSY.
REQ-008 In IDLE, stall_o SHALL be 0. In BUSY, stall_o SHALL equal ~dmem_ack_i.
REQ-009 Non-memory op (valid_i=1, mem_read_i=0, mem_write_i=0) in IDLE: the payload SHALL pass through to the outputs with 1-cycle latency; valid_o=1 and data_read_o=0.
REQ-010 If mem_read_i and mem_write_i are both 1, the op SHALL be treated as a load.
REQ-011 Aligned memory op in IDLE: the FSM SHALL latch the request and enter BUSY. While BUSY, dmem_req_o=1 and dmem_addr_o={alu_result_i[31:2],2'b00} (from the latched address).
REQ-012 While BUSY, the request SHALL be held stable until the cycle in which dmem_ack_i=1. At that edge: load the output registers, set valid_o=1, return to IDLE, and accept the next input in the same edge.
REQ-013 Zero-wait memory (ack in the first BUSY cycle) SHALL give 2-cycle input-to-valid_o latency. Each wait cycle adds 1.
REQ-014 valid_o SHALL be 0 in every cycle not produced by REQ-009, REQ-012 or REQ-017. Payload outputs hold their last value when valid_o=0.
REQ-015 Load formatting, lane = addr[1:0]:
  - LB (000) / LBU (100): byte at lane, sign-/zero-extended.
  - LH (001) / LHU (101): halfword at lane[1], sign-/zero-extended.
  - LW (010) and undefined codes (011, 110, 111): full word.
REQ-016 Stores SHALL drive dmem_we_o=1.
  - SB: be=4'b0001<<lane, wdata = byte replicated x4.
  - SH: be=4'b0011<<lane, wdata = halfword replicated x2.
  - SW: be=4'b1111, wdata = store_data_i.
  - Loads drive be=4'b1111 and dmem_we_o=0.
REQ-017 A misaligned op (halfword with addr[0]=1, word with addr[1:0]!=0) SHALL issue no dmem request and stay in IDLE. After 1 cycle it SHALL present valid_o=1, misaligned_o=1, reg_write_o=0, data_read_o=0.
REQ-018 misaligned_o SHALL be 0 on every other valid_o pulse.
REQ-019 dmem_ack_i in IDLE SHALL be ignored. dmem_rdata_i SHALL be sampled only on the ack edge.
REQ-020 A store completion SHALL pass reg_write_i unchanged and set data_read_o=0.

Reset
REQ-021 Asserting reset_i SHALL immediately force IDLE and drive all outputs to 0 (stall_o, dmem_req_o, dmem_we_o, dmem_be_o, valid_o, all payload outputs).
REQ-022 Reset during BUSY SHALL abandon the transaction: no writeback pulse, and dmem_req_o=0 from reset onward.
REQ-023 After reset_i deasserts, the first input SHALL be accepted at the next rising edge.

Verification
REQ-024 ALU pass-through: valid_i=1, alu_result_i=32'h0000_1234, no mem op -> next cycle valid_o=1, alu_result_o=32'h0000_1234, stall_o never high.
REQ-025 LB, 2 wait states: addr=32'h0000_0103, dmem_rdata_i=32'h80FF_0000, ack on 3rd BUSY cycle -> dmem_addr_o=32'h0000_0100, stall_o high 2 cycles, data_read_o=32'hFFFF_FF80. LBU with the same data -> 32'h0000_0080.
REQ-026 SH zero-wait: addr=32'h0000_0202, store_data_i=32'hAAAA_BEEF -> dmem_be_o=4'b1100, dmem_wdata_o=32'hBEEF_BEEF, dmem_we_o=1, valid_o 2 cycles after input.
REQ-027 LW at 32'h0000_0006 -> dmem_req_o stays 0, next cycle valid_o=1, misaligned_o=1, reg_write_o=0.
REQ-028 Reset in BUSY: assert reset_i mid-wait with ack pending -> dmem_req_o=0 at once, valid_o never pulses. A later ack is ignored; the FSM remains IDLE.
REQ-029 Back-to-back ops: LW (ack after 1 wait), then an ALU op held while stalled -> two consecutive valid_o pulses, with the ALU op's valid_o exactly 1 cycle after the LW's.

Source files
------------

// File: rtl/memory_access.sv
// Memory stage: forwards ALU results, runs one data-memory transaction at a time
// over a req/ack port, formats load/store lanes, and flags misaligned accesses.
module memory_access (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] pcsrc_i,
  input  logic [31:0] offset_i,
  input  logic [1:0]  mem_to_reg_i,
  input  logic [4:0]  rd_i,
  input  logic        reg_write_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        valid_o,
  output logic [31:0] data_read_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] pcsrc_o,
  output logic [31:0] offset_o,
  output logic [1:0]  mem_to_reg_o,
  output logic [4:0]  rd_o,
  output logic        reg_write_o,
  output logic        misaligned_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] pcsrc;
    logic [31:0] offset;
    logic [1:0]  mem_to_reg;
    logic [4:0]  rd;
    logic        reg_write;
  } payload_t;

  typedef struct packed {
    logic        misaligned;
    logic [31:0] data;
    payload_t    pl;
  } wb_t;

  state_t      state_q, state_d;
  logic        accept, issue, bypass, complete;
  logic        is_mem, is_store, misaligned_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_we;
  logic [2:0]  req_funct3;
  payload_t    req_pl;

  logic        pend_valid_q;
  wb_t         pend_wb_q;
  wb_t         byp_wb, mem_wb, out_wb;
  logic        out_load;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  // A read+write request is a load, so only pure writes count as stores.
  assign is_mem        = mem_read_i | mem_write_i;
  assign is_store      = mem_write_i & ~mem_read_i;
  assign misaligned_in = is_mem &
                         (((funct3_i[1:0] == 2'b01) & alu_result_i[0]) |
                          (funct3_i[1] & (alu_result_i[1:0] != 2'b00)));

  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d  = state_q;
    stall_o  = 1'b0;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: accept = valid_i;
      BUSY: begin
        stall_o  = ~dmem_ack_i;
        complete = dmem_ack_i;
        accept   = valid_i & dmem_ack_i;
        if (dmem_ack_i) state_d = IDLE;
      end
    endcase
    issue  = accept & is_mem & ~misaligned_in;
    bypass = accept & ~issue;
    if (issue) state_d = BUSY;
  end

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = store_data_i;
    if (is_store) begin
      case (funct3_i[1:0])
        2'b00: begin
          be_in    = 4'b0001 << alu_result_i[1:0];
          wdata_in = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          be_in    = 4'b0011 << alu_result_i[1:0];
          wdata_in = {2{store_data_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    byp_wb               = '0;
    byp_wb.misaligned    = misaligned_in;
    byp_wb.pl.alu_result = alu_result_i;
    byp_wb.pl.pcsrc      = pcsrc_i;
    byp_wb.pl.offset     = offset_i;
    byp_wb.pl.mem_to_reg = mem_to_reg_i;
    byp_wb.pl.rd         = rd_i;
    byp_wb.pl.reg_write  = reg_write_i & ~misaligned_in;
  end

  // NOTE: the request holding registers have no reset; the port is gated by BUSY, so stale contents never escape.
  always_ff @(posedge clk_i) begin
    if (issue) begin
      req_addr   <= alu_result_i;
      req_wdata  <= wdata_in;
      req_be     <= is_store ? be_in : 4'b1111;
      req_we     <= is_store;
      req_funct3 <= funct3_i;
      req_pl     <= byp_wb.pl;
    end
  end

  assign dmem_req_o   = (state_q == BUSY);
  assign dmem_we_o    = dmem_req_o & req_we;
  assign dmem_be_o    = dmem_req_o ? req_be : 4'b0000;
  assign dmem_addr_o  = dmem_req_o ? {req_addr[31:2], 2'b00} : 32'h0;
  assign dmem_wdata_o = dmem_req_o ? req_wdata : 32'h0;

  always_comb begin
    case (req_addr[1:0])
      2'b00:   lane_byte = dmem_rdata_i[7:0];
      2'b01:   lane_byte = dmem_rdata_i[15:8];
      2'b10:   lane_byte = dmem_rdata_i[23:16];
      default: lane_byte = dmem_rdata_i[31:24];
    endcase
    lane_half = req_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (req_funct3)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_data = {24'h0, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_data = {16'h0, lane_half};
      default: load_data = dmem_rdata_i;
    endcase
    mem_wb            = '0;
    mem_wb.data       = req_we ? 32'h0 : load_data;
    mem_wb.pl         = req_pl;
  end

  // A non-memory op accepted on the ack edge is parked one cycle behind the
  // completing transaction; the park slot drains at the first idle input.
  always_comb begin
    out_load = 1'b1;
    out_wb   = byp_wb;
    if (complete)          out_wb = mem_wb;
    else if (pend_valid_q) out_wb = pend_wb_q;
    else if (!bypass)      out_load = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_valid_q <= 1'b0;
      pend_wb_q    <= '0;
      valid_o      <= 1'b0;
      data_read_o  <= 32'h0;
      alu_result_o <= 32'h0;
      pcsrc_o      <= 32'h0;
      offset_o     <= 32'h0;
      mem_to_reg_o <= 2'b00;
      rd_o         <= 5'd0;
      reg_write_o  <= 1'b0;
      misaligned_o <= 1'b0;
    end else begin
      pend_valid_q <= bypass & (complete | pend_valid_q);
      if (bypass) pend_wb_q <= byp_wb;
      valid_o <= out_load;
      if (out_load) begin
        data_read_o  <= out_wb.data;
        alu_result_o <= out_wb.pl.alu_result;
        pcsrc_o      <= out_wb.pl.pcsrc;
        offset_o     <= out_wb.pl.offset;
        mem_to_reg_o <= out_wb.pl.mem_to_reg;
        rd_o         <= out_wb.pl.rd;
        reg_write_o  <= out_wb.pl.reg_write;
        misaligned_o <= out_wb.misaligned;
      end
    end
  end

endmodule
